three_bit_serial_subtractor: RTL and testbench

THREE_BIT_SERIAL_SUBTRACTOR -- requirements
Module: three_bit_serial_subtractor

---
 rtl/three_bit_serial_subtractor_pkg.sv | 12 +
 rtl/three_bit_serial_subtractor_full_subtractor.sv | 13 +
 rtl/three_bit_serial_subtractor.sv | 89 ++++++++
 tb/tb_three_bit_serial_subtractor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/three_bit_serial_subtractor_pkg.sv
// Shared state encoding and default operand width for the serial subtractor.
package three_bit_serial_subtractor_pkg;

  localparam int unsigned WIDTH_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/three_bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: difference and borrow-out of a - b - bin.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/three_bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B as a WIDTH+1 bit two's complement
// result, one bit per RUN cycle, LSB first.
module three_bit_serial_subtractor
  import three_bit_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   D,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res;

  full_subtractor u_fs (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_bin (r_borrow),
    .o_d   (w_d),
    .o_bout(w_bout)
  );

  // Result register with the current difference bit placed at position r_cnt
  always_comb begin
    w_res = r_diff;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_cnt == CW'(i)) w_res[i] = w_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      D        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_bout;
          r_diff   <= w_res;
          r_cnt    <= r_cnt + CW'(1);
          // Final borrow becomes the sign bit of the result
          if (r_cnt == CW'(WIDTH - 1)) begin
            D       <= {w_bout, w_res};
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_three_bit_serial_subtractor.sv
// Self-checking bench: per-cycle comparison against a timing/arithmetic model,
// directed literal cases, exhaustive sweep and randomized traffic.
module tb_three_bit_serial_subtractor;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W:0]   D;
  logic         busy;
  logic         done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: m_t = 0 when idle, k = k-th cycle after the accepting edge
  int         m_t   = 0;
  logic [W:0] m_res = '0;
  logic [W:0] m_D   = '0;

  three_bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .D    (D),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge, then compare shortly after
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_t = 0;
        m_D = '0;
      end else if (m_t == 0) begin
        if (start) begin
          m_t   = 1;
          m_res = (W+1)'({1'b0, A} - {1'b0, B});
        end
      end else if (m_t < int'(W) + 1) begin
        m_t++;
        if (m_t == int'(W) + 1) m_D = m_res;
      end else begin
        m_t = 0;
      end
      #1;
      check("busy", int'(busy), int'(m_t >= 1 && m_t <= int'(W)));
      check("done", int'(done), int'(m_t == int'(W) + 1));
      check("D", int'(D), int'(m_D));
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp, input string name);
    int lat;
    bit got;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 3'($urandom); B = 3'($urandom);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    check({name, "_done_seen"}, int'(got), 1);
    check({name, "_latency"}, lat, 2);
    check({name, "_D"}, int'(D), int'(exp));
    check({name, "_model_D"}, int'(m_D), int'(exp));
  endtask

  initial begin
    int dones;

    // Reset with start and operands active
    rst = 1'b1; start = 1'b1; A = 3'b111; B = 3'b001;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_D", int'(D), 0);
    end
    rst = 1'b0; start = 1'b0;

    run_op(3'b011, 3'b001, 4'b0010, "basic");
    run_op(3'b000, 3'b001, 4'b1111, "neg1");
    run_op(3'b000, 3'b111, 4'b1001, "neg2");
    run_op(3'b001, 3'b110, 4'b1011, "neg3");
    run_op(3'b111, 3'b000, 4'b0111, "maxpos");
    run_op(3'b111, 3'b111, 4'b0000, "equal");

    // Start pulses and operand churn during RUN are ignored
    @(negedge clk);
    A = 3'b110; B = 3'b010; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = 3'($urandom); B = 3'($urandom); start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    dones = int'(done);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dones += int'(done);
    end
    check("protect_done_count", dones, 1);
    check("protect_D", int'(D), 4'b0100);

    // Reset during the second RUN cycle aborts without done
    @(negedge clk);
    A = 3'b101; B = 3'b011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dones += int'(done);
    end
    check("abort_done_count", dones, 0);
    check("abort_D", int'(D), 0);
    run_op(3'b010, 3'b001, 4'b0001, "after_abort");

    // Exhaustive sweep
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        run_op(3'(a), 3'(b), 4'(a - b), "sweep");
      end
    end

    // Start held high: one accepted op every WIDTH+2 cycles
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      start = 1'b1; A = 3'($urandom); B = 3'($urandom);
      dones += int'(done);
    end
    check("held_start_done_count", dones, 5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 2) != 0);
      A     = 3'($urandom);
      B     = 3'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
